fetch_pc_gen: RTL and testbench

Parametrised fetch-address generator for the instruction front end, sitting between the redirect sources (writeback, execute, decode), the branch predictor and the icache request port. It holds the fetch-group PC, chooses the next PC by fixed priority, issues it to the icache over a valid/ready handshake, and supports a halt (idle) state that only writeback can leave. It also keeps saturating branch-prediction statistics counters for performance analysis.

---
 rtl/fetch_pc_gen_if.sv | 27 ++
 rtl/fetch_pc_gen.sv | 107 ++++++++++
 tb/tb_fetch_pc_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_if.sv
// Icache request channel between the fetch PC generator and the icache.
// Handshake: a request transfers in every cycle where icache_req_valid and
// icache_req_ready are both high at the rising clock edge. While valid is
// high and ready is low, icache_req_pc holds stable. Only a redirect may
// change it, and a redirect drops valid in that same cycle. icache_cancel
// is a one-cycle pulse that tells the icache to drop every outstanding
// response.
interface fetch_pc_gen_if;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_req_pc;
  logic        icache_cancel;

  modport master (
    output icache_req_valid,
    output icache_req_pc,
    output icache_cancel,
    input  icache_req_ready
  );

  modport slave (
    input  icache_req_valid,
    input  icache_req_pc,
    input  icache_cancel,
    output icache_req_ready
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-address generator. It holds the fetch-group PC and picks the next
// PC by fixed priority (wb > ex > id > accepted advance > hold). It issues
// requests to the icache and supports a HALT state that only a writeback
// redirect can leave. It also keeps saturating branch statistics.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h1C00_0000,
  parameter int          FETCH_WIDTH = 2,
  parameter int          CNT_W       = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                wb_redirect_valid,
  input  logic [31:0]         wb_redirect_pc,
  input  logic                ex_redirect_valid,
  input  logic [31:0]         ex_redirect_pc,
  input  logic                id_redirect_valid,
  input  logic [31:0]         id_redirect_pc,
  input  logic                bp_taken,
  input  logic [31:0]         bp_target,
  input  logic                stall_in,
  input  logic                halt_in,
  fetch_pc_gen_if.master      icache,
  output logic [31:0]         fetch_pc,
  input  logic                br_resolved,
  input  logic                br_mispredict,
  input  logic                stats_clear,
  output logic [CNT_W-1:0]    branch_count,
  output logic [CNT_W-1:0]    hit_count,
  output logic [1:0]          dbg_state_o
);

  localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);
  localparam logic [31:0] GROUP_MASK  = GROUP_BYTES - 32'd1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, hit_cnt_q;

  logic ex_take, id_take, any_redirect, req_valid, handshake;
  logic [31:0] seq_pc;

  // In HALT only writeback may redirect; ex/id corrections refer to
  // instructions that no longer matter.
  always_comb begin
    ex_take      = ex_redirect_valid && (state_q != HALT);
    id_take      = id_redirect_valid && (state_q != HALT);
    any_redirect = wb_redirect_valid || ex_take || id_take;
    req_valid    = (state_q == FETCH) && !stall_in && !any_redirect;
    handshake    = req_valid && icache.icache_req_ready;
    // Sequential advance realigns to the group boundary; wraps mod 2^32.
    seq_pc       = (fetch_pc_q & ~GROUP_MASK) + GROUP_BYTES;
  end

  // Next-PC selection by fixed priority.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (wb_redirect_valid)  fetch_pc_d = wb_redirect_pc;
    else if (ex_take)       fetch_pc_d = ex_redirect_pc;
    else if (id_take)       fetch_pc_d = id_redirect_pc;
    else if (handshake)     fetch_pc_d = bp_taken ? bp_target : seq_pc;
  end

  // Control FSM and the fetch PC register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      case (state_q)
        BOOT:    state_q <= FETCH;
        FETCH:   if (halt_in && !wb_redirect_valid) state_q <= HALT;
        HALT:    if (wb_redirect_valid) state_q <= FETCH;
        default: state_q <= BOOT;
      endcase
    end
  end

  // Saturating branch statistics; clear takes precedence over counting.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      branch_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else if (stats_clear) begin
      branch_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else if (br_resolved) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (!br_mispredict && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  assign icache.icache_req_valid = req_valid;
  assign icache.icache_req_pc    = fetch_pc_q;
  assign icache.icache_cancel    = any_redirect;
  assign fetch_pc                = fetch_pc_q;
  assign branch_count            = branch_cnt_q;
  assign hit_count               = hit_cnt_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed scenarios with a request scoreboard
// and a saturating-counter model (CNT_W=4).
module tb_fetch_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = 15;

  logic             aclk = 1'b0;
  logic             areset;
  logic             wb_redirect_valid, ex_redirect_valid, id_redirect_valid;
  logic [31:0]      wb_redirect_pc, ex_redirect_pc, id_redirect_pc;
  logic             bp_taken;
  logic [31:0]      bp_target;
  logic             stall_in, halt_in;
  logic [31:0]      fetch_pc;
  logic             br_resolved, br_mispredict, stats_clear;
  logic [CNT_W-1:0] branch_count, hit_count;
  logic [1:0]       dbg_state;

  fetch_pc_gen_if bus ();

  fetch_pc_gen #(
    .RESET_PC    (RESET_PC),
    .FETCH_WIDTH (2),
    .CNT_W       (CNT_W)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .wb_redirect_valid (wb_redirect_valid),
    .wb_redirect_pc    (wb_redirect_pc),
    .ex_redirect_valid (ex_redirect_valid),
    .ex_redirect_pc    (ex_redirect_pc),
    .id_redirect_valid (id_redirect_valid),
    .id_redirect_pc    (id_redirect_pc),
    .bp_taken          (bp_taken),
    .bp_target         (bp_target),
    .stall_in          (stall_in),
    .halt_in           (halt_in),
    .icache            (bus.master),
    .fetch_pc          (fetch_pc),
    .br_resolved       (br_resolved),
    .br_mispredict     (br_mispredict),
    .stats_clear       (stats_clear),
    .branch_count      (branch_count),
    .hit_count         (hit_count),
    .dbg_state_o       (dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int exp_br = 0;
  int exp_hit = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // driver helpers: inputs change 1 time unit after the rising edge,
  // outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  // scoreboard: every accepted request is compared against the queue
  always @(negedge aclk) begin
    if (!areset && bus.icache_req_valid && bus.icache_req_ready) begin
      if (exp_q.size() == 0) check_val("unexpected_req", bus.icache_req_pc, 32'hFFFF_FFFF);
      else check_val("req_pc", bus.icache_req_pc, exp_q.pop_front());
    end
  end

  initial begin
    areset = 1'b1;
    wb_redirect_valid = 1'b0; ex_redirect_valid = 1'b0; id_redirect_valid = 1'b0;
    wb_redirect_pc = '0; ex_redirect_pc = '0; id_redirect_pc = '0;
    bp_taken = 1'b0; bp_target = '0; stall_in = 1'b0; halt_in = 1'b0;
    br_resolved = 1'b0; br_mispredict = 1'b0; stats_clear = 1'b0;
    bus.icache_req_ready = 1'b0;

    // reset values
    repeat (2) sample();
    check_val("rst_pc", fetch_pc, RESET_PC);
    check_val("rst_valid", 32'(bus.icache_req_valid), 32'd0);
    check_val("rst_cancel", 32'(bus.icache_cancel), 32'd0);
    check_val("rst_bcnt", 32'(branch_count), 32'd0);
    check_val("rst_hcnt", 32'(hit_count), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);

    // release: BOOT now, sequential requests from cycle 1
    areset = 1'b0;
    bus.icache_req_ready = 1'b1;
    exp_q.push_back(32'h1C00_0000);
    exp_q.push_back(32'h1C00_0008);
    exp_q.push_back(32'h1C00_0010);
    #1;
    check_val("boot_valid", 32'(bus.icache_req_valid), 32'd0);
    check_val("boot_state", 32'(dbg_state), 32'd0);
    next_cycle(); sample();
    check_val("c1_valid", 32'(bus.icache_req_valid), 32'd1);
    check_val("c1_pc", bus.icache_req_pc, RESET_PC);
    next_cycle(); sample();
    next_cycle(); sample();

    // unaligned id redirect drops valid and cancels
    next_cycle();
    check_val("pre_redir_pc", fetch_pc, 32'h1C00_0018);
    id_redirect_valid = 1'b1; id_redirect_pc = 32'h1C00_0104;
    exp_q.push_back(32'h1C00_0104);
    exp_q.push_back(32'h1C00_0108);
    sample();
    check_val("redir_valid", 32'(bus.icache_req_valid), 32'd0);
    check_val("redir_cancel", 32'(bus.icache_cancel), 32'd1);
    next_cycle();
    id_redirect_valid = 1'b0;
    sample();
    check_val("redir_pc", fetch_pc, 32'h1C00_0104);
    check_val("redir_cancel_off", 32'(bus.icache_cancel), 32'd0);
    next_cycle(); sample();

    // back-pressure: pc stable while ready is low
    next_cycle();
    bus.icache_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_val("bp_valid", 32'(bus.icache_req_valid), 32'd1);
      check_val("bp_pc", bus.icache_req_pc, 32'h1C00_0110);
      next_cycle();
    end
    // stall: valid low, pc held
    stall_in = 1'b1;
    sample();
    check_val("stall_valid", 32'(bus.icache_req_valid), 32'd0);
    next_cycle(); sample();
    check_val("stall_pc", fetch_pc, 32'h1C00_0110);
    // predicted-taken accept
    next_cycle();
    stall_in = 1'b0; bus.icache_req_ready = 1'b1;
    bp_taken = 1'b1; bp_target = 32'h1C00_0400;
    exp_q.push_back(32'h1C00_0110);
    exp_q.push_back(32'h1C00_0400);
    sample();
    next_cycle();
    bp_taken = 1'b0;
    sample();

    // simultaneous wb/ex/id: wb wins, one cancel pulse
    next_cycle();
    bus.icache_req_ready = 1'b0;
    wb_redirect_valid = 1'b1; wb_redirect_pc = 32'h1C00_1000;
    ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h1C00_2000;
    id_redirect_valid = 1'b1; id_redirect_pc = 32'h1C00_3000;
    sample();
    check_val("tri_cancel", 32'(bus.icache_cancel), 32'd1);
    check_val("tri_valid", 32'(bus.icache_req_valid), 32'd0);
    next_cycle();
    wb_redirect_valid = 1'b0; ex_redirect_valid = 1'b0; id_redirect_valid = 1'b0;
    sample();
    check_val("tri_pc", fetch_pc, 32'h1C00_1000);
    check_val("tri_cancel_off", 32'(bus.icache_cancel), 32'd0);

    // halt: ex ignored, wb exits
    next_cycle();
    halt_in = 1'b1;
    next_cycle();
    halt_in = 1'b0;
    sample();
    check_val("halt_state", 32'(dbg_state), 32'd2);
    check_val("halt_valid", 32'(bus.icache_req_valid), 32'd0);
    next_cycle();
    ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h1C00_2000;
    sample();
    check_val("halt_ex_cancel", 32'(bus.icache_cancel), 32'd0);
    next_cycle();
    ex_redirect_valid = 1'b0;
    sample();
    check_val("halt_ex_pc", fetch_pc, 32'h1C00_1000);
    check_val("halt_ex_state", 32'(dbg_state), 32'd2);
    next_cycle();
    wb_redirect_valid = 1'b1; wb_redirect_pc = 32'h1C00_8000;
    bus.icache_req_ready = 1'b1;
    exp_q.push_back(32'h1C00_8000);
    sample();
    check_val("halt_wb_cancel", 32'(bus.icache_cancel), 32'd1);
    next_cycle();
    wb_redirect_valid = 1'b0;
    sample();
    check_val("halt_exit_state", 32'(dbg_state), 32'd1);

    // address wrap at the top of the space
    next_cycle();
    bus.icache_req_ready = 1'b0;
    wb_redirect_valid = 1'b1; wb_redirect_pc = 32'hFFFF_FFF8;
    next_cycle();
    wb_redirect_valid = 1'b0; bus.icache_req_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'h0000_0000);
    sample();
    next_cycle(); sample();
    next_cycle();
    bus.icache_req_ready = 1'b0;
    sample();
    check_val("wrap_pc", fetch_pc, 32'h0000_0008);

    // statistics: 20 branches, 5 mispredicts, saturating at 15
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      br_resolved = 1'b1;
      br_mispredict = (i % 4 == 0);
      sample();
      check_val("bcnt", 32'(branch_count), 32'(exp_br));
      check_val("hcnt", 32'(hit_count), 32'(exp_hit));
      if (exp_br < CNT_MAX) exp_br++;
      if (!br_mispredict && exp_hit < CNT_MAX) exp_hit++;
    end
    next_cycle();
    br_resolved = 1'b0; br_mispredict = 1'b0;
    sample();
    check_val("bcnt_sat", 32'(branch_count), 32'd15);
    check_val("hcnt_sat", 32'(hit_count), 32'd15);
    next_cycle();
    stats_clear = 1'b1; br_resolved = 1'b1;
    next_cycle();
    stats_clear = 1'b0; br_resolved = 1'b0;
    sample();
    check_val("bcnt_clr", 32'(branch_count), 32'd0);
    check_val("hcnt_clr", 32'(hit_count), 32'd0);

    // asynchronous reset mid-operation
    next_cycle();
    #1;
    areset = 1'b1;
    #1;
    check_val("mid_rst_pc", fetch_pc, RESET_PC);
    check_val("mid_rst_state", 32'(dbg_state), 32'd0);
    check_val("mid_rst_cancel", 32'(bus.icache_cancel), 32'd0);
    check_val("mid_rst_valid", 32'(bus.icache_req_valid), 32'd0);
    sample();
    areset = 1'b0;

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
